// File: rtl/bit_diff_if_pkg.sv
// Shared widths for bit_diff and the blocks that talk to it.
`default_nettype none

package bit_diff_if_pkg;

    localparam int WIDTH        = 16;
    // Signed range of (ones - zeros) over WIDTH bits is [-WIDTH, +WIDTH].
    localparam int RESULT_WIDTH = $clog2(2*WIDTH+1);

endpackage

`default_nettype wire

// File: rtl/bit_diff_fifo.sv
// Show-ahead FIFO: rd_data_o is the head word whenever empty_o is low.
`default_nettype none

module bit_diff_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic             do_push;
    logic             do_pop;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bit_diff_sequencer.sv
// Streams queued words through the single-shot bit_diff engine and returns
// each signed result with its source word, aborting stuck computations.
`default_nettype none

module bit_diff_sequencer #(
    parameter int WIDTH        = bit_diff_if_pkg::WIDTH,
    parameter int RESULT_WIDTH = bit_diff_if_pkg::RESULT_WIDTH,
    parameter int DEPTH        = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    dut_go,
    output logic [WIDTH-1:0]        dut_data,
    input  logic                    dut_done,
    input  logic [RESULT_WIDTH-1:0] dut_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RESULT_WIDTH-1:0] out_result,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_timeout,
    output logic                    busy
);

    import bit_diff_if_pkg::*;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GO   = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam int              TW      = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   WD_LAST = TW'(TIMEOUT - 1);
    localparam int              CW      = $clog2(DEPTH+1);

    state_t                  state_q;
    logic [TW-1:0]           wd_cnt_q;
    logic                    dut_go_q;
    logic [WIDTH-1:0]        dut_data_q;
    logic                    out_valid_q;
    logic [RESULT_WIDTH-1:0] out_result_q;
    logic [WIDTH-1:0]        out_data_q;
    logic                    out_timeout_q;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic [WIDTH-1:0]        fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;
    logic                    wd_expire;

    bit_diff_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (fifo_push),
        .wr_data_i (in_data),
        .pop_i     (fifo_pop),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign in_ready  = !fifo_full;
    assign busy      = (fifo_count != '0) || (state_q != S_IDLE);
    assign fifo_push = in_valid && in_ready;
    assign wd_expire = (wd_cnt_q == WD_LAST);
    // The word stays at the FIFO head until its WAIT phase ends.
    assign fifo_pop  = (state_q == S_WAIT) && (dut_done || wd_expire);

    assign dut_go      = dut_go_q;
    assign dut_data    = dut_data_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_data    = out_data_q;
    assign out_timeout = out_timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wd_cnt_q      <= '0;
            dut_go_q      <= 1'b0;
            dut_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_data_q    <= '0;
            out_timeout_q <= 1'b0;
        end else begin
            dut_go_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state_q    <= S_GO;
                        dut_go_q   <= 1'b1;
                        dut_data_q <= fifo_head;
                    end
                end
                // done may still be high from the previous word, so it is not looked at here.
                S_GO: begin
                    state_q  <= S_WAIT;
                    wd_cnt_q <= '0;
                end
                S_WAIT: begin
                    if (dut_done) begin
                        state_q       <= S_HOLD;
                        out_valid_q   <= 1'b1;
                        out_result_q  <= dut_result;
                        out_data_q    <= fifo_head;
                        out_timeout_q <= 1'b0;
                        wd_cnt_q      <= '0;
                    end else if (wd_expire) begin
                        state_q       <= S_HOLD;
                        out_valid_q   <= 1'b1;
                        out_result_q  <= '0;
                        out_data_q    <= fifo_head;
                        out_timeout_q <= 1'b1;
                        wd_cnt_q      <= '0;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + TW'(1);
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (!fifo_empty) begin
                            state_q    <= S_GO;
                            dut_go_q   <= 1'b1;
                            dut_data_q <= fifo_head;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bit_diff_sequencer.sv
// Bench for bit_diff_sequencer: a bit_diff engine model with per-word latency
// plus a queue-based reference of the expected result stream and timing.
`default_nettype none

module tb_bit_diff_sequencer;

    localparam int W     = bit_diff_if_pkg::WIDTH;
    localparam int RW    = bit_diff_if_pkg::RESULT_WIDTH;
    localparam int DEPTH = 4;
    localparam int TO    = 24;
    localparam int NEVER = 1000;

    typedef struct {
        logic [W-1:0] w;
        int           lat;
        bit           st;
    } item_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          dut_go;
    logic [W-1:0]  dut_data;
    logic          dut_done;
    logic [RW-1:0] dut_result;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_result;
    logic [W-1:0]  out_data;
    logic          out_timeout;
    logic          busy;

    logic          ready_fixed = 1'b1;
    logic          rnd_en      = 1'b0;
    logic          rnd_r       = 1'b1;
    assign out_ready = rnd_en ? rnd_r : ready_fixed;

    bit_diff_sequencer #(
        .WIDTH(W), .RESULT_WIDTH(RW), .DEPTH(DEPTH), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dut_go(dut_go), .dut_data(dut_data),
        .dut_done(dut_done), .dut_result(dut_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_data(out_data),
        .out_timeout(out_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     acc_cyc = 0;
    int     go_cyc = 0;
    int     go_count = 0;
    int     occ = 0;
    int     nx_lat = 1;
    bit     nx_st = 1'b0;
    item_t  cur;
    item_t  issue_q[$];
    item_t  exp_q[$];
    longint got_q[$];
    longint got_to_q[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint bitdiff(input logic [W-1:0] w);
        return longint'(2 * $countones(w) - W);
    endfunction

    function automatic longint exp_res(input item_t it);
        return (it.lat > TO) ? 0 : bitdiff(it.w);
    endfunction

    // Accepted words enter both the issue order and the result order.
    always @(posedge clk) begin
        cyc++;
        if (rst_n && in_valid && in_ready) begin
            item_t it;
            it.w = in_data; it.lat = nx_lat; it.st = nx_st;
            issue_q.push_back(it);
            exp_q.push_back(it);
            occ++;
            acc_cyc = cyc;
        end
    end

    // bit_diff engine model: done is a level that rises lat cycles after go and
    // stays high until the next go (one extra GO cycle when the word is sticky).
    initial begin : engine
        int  cnt;
        bit  active;
        cnt = 0; active = 1'b0;
        dut_done = 1'b0; dut_result = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                active = 1'b0; dut_done = 1'b0;
            end else if (dut_go) begin
                go_count++;
                chk("go_has_word", longint'(issue_q.size() != 0), 1);
                if (issue_q.size() != 0) cur = issue_q.pop_front();
                go_cyc = cyc; cnt = cur.lat; active = 1'b1;
                if (!cur.st) dut_done = 1'b0;
            end else if (active) begin
                dut_done = 1'b0;
                cnt--;
                if (cnt <= 0) begin
                    dut_done = 1'b1;
                    dut_result = RW'(bitdiff(cur.w));
                    active = 1'b0;
                end
            end
        end
    end

    initial begin : rnd_ready
        forever begin
            @(posedge clk); #2;
            rnd_r = 1'($urandom_range(0, 1));
        end
    end

    // Per-cycle comparison against the reference.
    initial begin : compare
        bit           pv, pr, pg, new_txn;
        logic [W-1:0] pd;
        logic [RW-1:0] pres;
        logic         pto;
        pv = 0; pr = 0; pg = 0; pd = '0; pres = '0; pto = 0;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                pv = 0; pr = 0; pg = 0;
            end else begin
                new_txn = out_valid && (!pv || pr);
                if (new_txn) begin
                    occ--;
                    chk("out_valid_timing", cyc,
                        longint'(go_cyc + ((cur.lat < TO) ? cur.lat : TO) + 1));
                end
                chk("in_ready", in_ready, longint'(occ < DEPTH));
                chk("busy", busy, longint'(occ > 0 || out_valid));
                if (dut_go) begin
                    chk("go_single_cycle", pg, 0);
                    chk("go_data", dut_data, cur.w);
                end
                if (out_valid && pv && !pr) begin
                    chk("hold_data", out_data, pd);
                    chk("hold_result", out_result, pres);
                    chk("hold_timeout", out_timeout, pto);
                end
                if (out_valid && out_ready) begin
                    chk("out_expected", longint'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        item_t e;
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e.w);
                        chk("out_result", longint'($signed(out_result)), exp_res(e));
                        chk("out_timeout", out_timeout, longint'(e.lat > TO));
                        got_q.push_back(longint'($signed(out_result)));
                        got_to_q.push_back(longint'(out_timeout));
                    end
                end
                pv = out_valid; pr = out_ready; pg = dut_go;
                pd = out_data; pres = out_result; pto = out_timeout;
            end
        end
    end

    task automatic push(input logic [W-1:0] w, input int lat, input bit st);
        int n = 0;
        in_valid = 1'b1; in_data = w; nx_lat = lat; nx_st = st;
        while (!in_ready && n < 500) begin
            @(negedge clk); n++;
        end
        if (n >= 500) begin
            chk("push_accepted", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk); n++;
        end
        chk("drain_complete", longint'(n < 3000), 1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_dut_go", dut_go, 0);
        chk("rst_dut_data", dut_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_timeout", out_timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench did not terminate");
    end

    initial begin : main
        int g0, n;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #2; rst_n = 1'b1;
        @(negedge clk);

        // Single word, 17-cycle engine latency.
        got_q.delete(); got_to_q.delete();
        push(16'hFFFF, 17, 1'b0);
        drain();
        chk("t1_go_count", go_count, 1);
        chk("t1_go_latency", go_cyc - acc_cyc, 1);
        chk("t1_result", got_q.size() > 0 ? got_q[0] : 99, 16);
        chk("t1_timeout", got_to_q.size() > 0 ? got_to_q[0] : 99, 0);

        // Short stream with the consumer always ready.
        got_q.delete(); got_to_q.delete();
        push(16'h0000, 3, 1'b0);
        push(16'h00FF, 5, 1'b0);
        push(16'h0001, 2, 1'b0);
        drain();
        chk("t2_count", got_q.size(), 3);
        chk("t2_r0", got_q.size() > 0 ? got_q[0] : 99, -16);
        chk("t2_r1", got_q.size() > 1 ? got_q[1] : 99, 0);
        chk("t2_r2", got_q.size() > 2 ? got_q[2] : 99, -14);

        // Back-pressure: fill the FIFO while the consumer stalls.
        got_q.delete(); got_to_q.delete();
        ready_fixed = 1'b0;
        for (int i = 0; i < 4; i++) push(W'($urandom), 20, 1'b0);
        chk("t3_full_after_4", in_ready, 0);
        repeat (30) @(negedge clk);
        push(W'($urandom), 4, 1'b0);
        ready_fixed = 1'b1;
        push(W'($urandom), 6, 1'b0);
        drain();
        chk("t3_count", got_q.size(), 6);

        // Stale-high done across the GO cycle must not be captured.
        got_q.delete(); got_to_q.delete();
        push(16'hFFFF, 4, 1'b0);
        drain();
        push(16'h7000, 5, 1'b1);
        drain();
        chk("t4_stale_result", got_q.size() > 1 ? got_q[1] : 99, -10);

        // Watchdog: never-done, done exactly at the limit, one cycle past it.
        got_q.delete(); got_to_q.delete();
        push(16'h1234, NEVER, 1'b0);
        push(16'h8001, TO, 1'b0);
        push(16'h0FFF, TO + 1, 1'b0);
        drain();
        chk("t5_r0", got_q.size() > 0 ? got_q[0] : 99, 0);
        chk("t5_to0", got_to_q.size() > 0 ? got_to_q[0] : 99, 1);
        chk("t5_r1", got_q.size() > 1 ? got_q[1] : 99, -12);
        chk("t5_to1", got_to_q.size() > 1 ? got_to_q[1] : 99, 0);
        chk("t5_to2", got_to_q.size() > 2 ? got_to_q[2] : 99, 1);

        // Randomized traffic with random consumer stalls.
        rnd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int lat;
            lat = $urandom_range(1, 30);
            push(W'($urandom), lat, (lat >= 3) && ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rnd_en = 1'b0;
        drain();

        // Reset while a word is in WAIT and more are queued.
        for (int i = 0; i < 3; i++) push(W'($urandom), NEVER, 1'b0);
        n = 0;
        while (go_count == 0 && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        #2; rst_n = 1'b0;
        #1;
        check_reset_outputs();
        issue_q.delete(); exp_q.delete(); occ = 0;
        @(posedge clk); #2; rst_n = 1'b1;
        @(negedge clk);
        g0 = go_count;
        repeat (12) @(negedge clk);
        chk("t7_no_go_after_reset", go_count - g0, 0);
        chk("t7_idle_busy", busy, 0);
        got_q.delete(); got_to_q.delete();
        push(16'h0003, 2, 1'b0);
        drain();
        chk("t7_post_reset_result", got_q.size() > 0 ? got_q[0] : 99, -12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bit_diff_sequencer.md
# bit_diff_sequencer

Upstream/downstream companion to `bit_diff`:
- Accepts a valid/ready stream of WIDTH-bit words into a small FIFO.
- Issues each word to `bit_diff` with a `go` pulse, waits for `done`, and returns the signed result plus the original word on a valid/ready output stream.
- Turns `bit_diff`'s single-shot go/done interface into a back-pressured stream for the rest of the design.
- A watchdog flags words whose computation never completes.

## Interface
- WIDTH, bit_diff_if_pkg::WIDTH (16), input word width
- RESULT_WIDTH, bit_diff_if_pkg::RESULT_WIDTH ($clog2(2*WIDTH+1), 6), signed result width
- DEPTH, 4, FIFO entries; power of two, ≥2
- TIMEOUT, 64, max cycles in WAIT before abort; ≥2
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input word valid
- in_ready  out  1  FIFO not full
- in_data  in  WIDTH  input word
- dut_go  out  1  start pulse to bit_diff
- dut_data  out  WIDTH  word to bit_diff
- dut_done  in  1  bit_diff done (level)
- dut_result  in  RESULT_WIDTH  bit_diff result, signed
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_result  out  RESULT_WIDTH  signed result (0 on timeout)
- out_data  out  WIDTH  word that produced the result
- out_timeout  out  1  result aborted by watchdog
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- FIFO push on `in_valid && in_ready`; `in_ready = !full`.
- FIFO pop on leaving WAIT (done or timeout).
- Push and pop in the same cycle is legal; count is unchanged.
- FSM states and transitions:
  - IDLE → GO when FIFO non-empty.
  - GO: `dut_go=1` for exactly one cycle; `dut_data` = FIFO head, held stable through WAIT. GO → WAIT unconditionally. `dut_done` is ignored in GO, because it may be stale-high from the previous word.
  - WAIT: the watchdog counts from 0.
    - On `dut_done=1`: capture `dut_result` and head into the output registers, clear `out_timeout`, pop, go to HOLD.
    - Else, when the counter reaches TIMEOUT-1: capture result 0 and head, set `out_timeout`, pop, go to HOLD.
  - HOLD: `out_valid=1`. On `out_ready`, go to GO if the FIFO is non-empty after the pop, else IDLE.
- Output registers stay stable while `out_valid && !out_ready`.
- `out_result` is a sign-preserving copy of `dut_result`; no arithmetic is performed here.
- Reset, including mid-operation, returns to:
  - FSM in IDLE; FIFO emptied (rd/wr pointers and count = 0); watchdog cleared.
  - `dut_go`=0, `dut_data`=0, `out_valid`=0, `out_result`=0, `out_data`=0, `out_timeout`=0, `busy`=0, `in_ready`=1.
  - Words in flight are discarded.

## Timing
- Push at edge E0 into an empty FIFO in IDLE: FSM is in GO, with `dut_go` high, in the cycle after E1.
- `dut_done` first high in WAIT in cycle C: `out_valid` high from cycle C+1.
- Back-to-back: HOLD accepted in cycle H with FIFO non-empty gives `dut_go` high in cycle H+1.
- The watchdog measures cycles spent in WAIT. Timeout fires in WAIT cycle TIMEOUT; `out_valid` is high the next cycle.
- FIFO full: `in_ready`=0 the cycle after the DEPTH-th push. A pop alone re-raises it the following cycle.
- All outputs are registered except `in_ready` and `busy`, which are decoded from registered state.

## Structure
- Add `localparam int RESULT_WIDTH = $clog2(2*WIDTH+1)` to `bit_diff_if_pkg`. Interface and testbench instantiations share it.
- The FSM state enum lives locally in the module.
- One sub-module, `bit_diff_fifo`: parameterized WIDTH/DEPTH, show-ahead `rd_data`, full/empty/count, same reset. The FSM, watchdog and output register stay in `bit_diff_sequencer`.

## Test plan
- Single word 0xFFFF with a bench `bit_diff` model (done 17 cycles after go) → exactly one `dut_go` pulse; `out_result`=+16, `out_data`=0xFFFF, `out_timeout`=0.
- Stream 0x0000, 0x00FF, 0x0001 with `out_ready`=1 → results −16, 0, −14 in order; each `dut_go` a single-cycle pulse.
- Hold `out_ready`=0 while pushing 6 words, DEPTH=4:
  - `in_ready` drops after the 4th push and outputs stay stable.
  - Release → all words emerge in order with none lost or duplicated.
- Model leaves `dut_done` stuck high from a prior word → GO-cycle `done` is ignored; the result is captured only after `done` falls and rises again.
- Model never raises `done`, TIMEOUT=8 → `out_timeout`=1 and `out_result`=0 after 8 WAIT cycles; the next queued word proceeds normally.
- Assert `rst_n`=0 during WAIT with 3 words queued → all outputs at reset values immediately; after release, no `dut_go` until new input arrives.
